// File: rtl/tetris_pkg.sv
// Shared definitions for the board bus reader/transmitter.
//   ROWS, COLS, BOARD_W, ROW_IDX_W : board geometry constants
//   scan_state_t                   : transmitter state encoding
//   row_slice()                    : extracts one row of cells from a board
package tetris_pkg;

  localparam int ROWS      = 8;
  localparam int COLS      = 4;
  localparam int BOARD_W   = ROWS * COLS;
  localparam int ROW_IDX_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // Row r occupies board[r*COLS +: COLS].
  function automatic logic [COLS-1:0] row_slice(input logic [BOARD_W-1:0]   board,
                                                input logic [ROW_IDX_W-1:0] r);
    return board[r*COLS +: COLS];
  endfunction

endpackage

// File: rtl/scan_gap_timer.sv
// Loadable down-counter that times the idle gap between row transfers.
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset (count returns to 0)
//   load_i     : load load_val_i into the counter
//   load_val_i : number of gap cycles to time
//   en_i       : high while the gap is in progress; counter decrements
//   done_o     : high in the final gap cycle
module scan_gap_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The first gap cycle sees the loaded value, so the last one sees 1.
  assign done_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/board_scan_tx.sv
// Board bus reader/transmitter: captures a 32-bit board snapshot and streams
// it row by row to the LED-matrix row driver, freezing the snapshot while the
// frame is in flight.
// Optional build macro CHANGE_ONLY_EN: an accepted board equal to the last
// fully transmitted board is consumed without sending any rows.
// Ports:
//   clka        : sole clock, rising edge
//   restart_n   : asynchronous active-low reset
//   board_in    : board snapshot, row r = board_in[r*COLS +: COLS]
//   board_valid : board_in valid
//   board_ready : a board can be accepted (IDLE only)
//   row_data    : cells of the current row
//   row_idx     : index of the current row
//   row_valid   : row_data/row_idx valid
//   row_ready   : row driver accepts the row
//   frame_done  : one-cycle pulse after the last row is accepted
//   busy        : frame in progress
module board_scan_tx
  import tetris_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clka,
  input  logic                 restart_n,
  input  logic [BOARD_W-1:0]   board_in,
  input  logic                 board_valid,
  output logic                 board_ready,
  output logic [COLS-1:0]      row_data,
  output logic [ROW_IDX_W-1:0] row_idx,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic                 frame_done,
  output logic                 busy
);

  // Wide enough to hold GAP_CYCLES and never zero width.
  localparam int CNT_W = $clog2(GAP_CYCLES + 2);

  scan_state_t          state_q, state_d;
  logic [BOARD_W-1:0]   snap_q, snap_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic                 done_q, done_d;

  logic accept;
  logic take_frame;
  logic row_hs;
  logic last_row;
  logic gap_load;
  logic gap_done;

  assign board_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign row_valid   = (state_q == SEND);
  assign row_idx     = row_q;
  assign row_data    = row_slice(snap_q, row_q);
  assign frame_done  = done_q;

  assign accept   = board_valid && board_ready;
  assign row_hs   = row_valid && row_ready;
  assign last_row = (row_q == ROW_IDX_W'(ROWS - 1));

`ifdef CHANGE_ONLY_EN
  logic [BOARD_W-1:0] last_sent_q;

  // A repeat of the last completed board is consumed but starts no frame.
  assign take_frame = accept && (board_in != last_sent_q);

  // Only a completed frame updates last_sent; an aborted one never gets here.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      last_sent_q <= '0;
    end else if (row_hs && last_row) begin
      last_sent_q <= snap_q;
    end
  end
`else
  assign take_frame = accept;
`endif

  scan_gap_timer #(
    .CNT_W(CNT_W)
  ) u_gap_timer (
    .clk_i     (clka),
    .rst_ni    (restart_n),
    .load_i    (gap_load),
    .load_val_i(CNT_W'(GAP_CYCLES)),
    .en_i      (state_q == GAP),
    .done_o    (gap_done)
  );

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    row_d    = row_q;
    done_d   = 1'b0;
    gap_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take_frame) begin
          snap_d  = board_in;
          row_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (row_hs) begin
          if (last_row) begin
            // No gap after the final row; IDLE next cycle can take a new board.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d  = GAP;
              gap_load = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_board_scan_tx.sv
// Self-checking bench for board_scan_tx: two instances (no gap, 2-cycle gap)
// share stimulus and are each compared every cycle against a frame-level
// behavioural model.
module tb_board_scan_tx;
  import tetris_pkg::*;

  localparam int G0 = 0;
  localparam int G1 = 2;
`ifdef CHANGE_ONLY_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic                 clka = 1'b0;
  logic                 restart_n;
  logic [BOARD_W-1:0]   board_in;
  logic                 board_valid;
  logic                 row_ready;

  logic [1:0]                board_ready_w;
  logic [1:0]                row_valid_w;
  logic [1:0]                frame_done_w;
  logic [1:0]                busy_w;
  logic [1:0][COLS-1:0]      row_data_w;
  logic [1:0][ROW_IDX_W-1:0] row_idx_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clka = ~clka;

  board_scan_tx #(.GAP_CYCLES(G0)) dut_a (
    .clka       (clka),
    .restart_n  (restart_n),
    .board_in   (board_in),
    .board_valid(board_valid),
    .board_ready(board_ready_w[0]),
    .row_data   (row_data_w[0]),
    .row_idx    (row_idx_w[0]),
    .row_valid  (row_valid_w[0]),
    .row_ready  (row_ready),
    .frame_done (frame_done_w[0]),
    .busy       (busy_w[0])
  );

  board_scan_tx #(.GAP_CYCLES(G1)) dut_b (
    .clka       (clka),
    .restart_n  (restart_n),
    .board_in   (board_in),
    .board_valid(board_valid),
    .board_ready(board_ready_w[1]),
    .row_data   (row_data_w[1]),
    .row_idx    (row_idx_w[1]),
    .row_valid  (row_valid_w[1]),
    .row_ready  (row_ready),
    .frame_done (frame_done_w[1]),
    .busy       (busy_w[1])
  );

  // Reference model: a frame is "busy" with a current row and a number of
  // idle cycles still to wait before that row is offered.
  bit          m_busy [2];
  int          m_row  [2];
  int          m_wait [2];
  logic [31:0] m_snap [2];
  bit          m_done [2];
  logic [31:0] m_last [2];

  always @(posedge clka or negedge restart_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!restart_n) begin
        m_busy[k] <= 1'b0;
        m_row[k]  <= 0;
        m_wait[k] <= 0;
        m_snap[k] <= '0;
        m_done[k] <= 1'b0;
        m_last[k] <= '0;
      end else begin
        m_done[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (board_valid && !(CHG && (board_in == m_last[k]))) begin
            m_busy[k] <= 1'b1;
            m_row[k]  <= 0;
            m_wait[k] <= 0;
            m_snap[k] <= board_in;
          end
        end else if (m_wait[k] > 0) begin
          m_wait[k] <= m_wait[k] - 1;
        end else if (row_ready) begin
          if (m_row[k] == ROWS - 1) begin
            m_busy[k] <= 1'b0;
            m_done[k] <= 1'b1;
            m_last[k] <= m_snap[k];
          end else begin
            m_row[k]  <= m_row[k] + 1;
            m_wait[k] <= (k == 0) ? G0 : G1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic        ev;
      logic [31:0] ed;
      ev = m_busy[k] && (m_wait[k] == 0);
      ed = (m_snap[k] >> (m_row[k] * COLS)) & ((32'h1 << COLS) - 1);
      chk($sformatf("board_ready%0d", k), 32'(board_ready_w[k]), 32'(!m_busy[k]));
      chk($sformatf("busy%0d", k),        32'(busy_w[k]),        32'(m_busy[k]));
      chk($sformatf("row_valid%0d", k),   32'(row_valid_w[k]),   32'(ev));
      chk($sformatf("frame_done%0d", k),  32'(frame_done_w[k]),  32'(m_done[k]));
      if (ev) begin
        chk($sformatf("row_idx%0d", k),  32'(row_idx_w[k]),  32'(m_row[k]));
        chk($sformatf("row_data%0d", k), 32'(row_data_w[k]), ed);
      end
    end
  endtask

  task automatic tick();
    @(negedge clka);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] b, input logic r);
    board_valid = v;
    board_in    = b;
    row_ready   = r;
  endtask

  // Called just after a negedge: assert reset asynchronously, check the
  // outputs before any clock edge, release at the next negedge.
  task automatic do_reset();
    restart_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready%0d", k),  32'(board_ready_w[k]), 32'd1);
      chk($sformatf("rst_valid%0d", k),  32'(row_valid_w[k]),   32'd0);
      chk($sformatf("rst_busy%0d", k),   32'(busy_w[k]),        32'd0);
      chk($sformatf("rst_done%0d", k),   32'(frame_done_w[k]),  32'd0);
      chk($sformatf("rst_data%0d", k),   32'(row_data_w[k]),    32'd0);
      chk($sformatf("rst_idx%0d", k),    32'(row_idx_w[k]),     32'd0);
    end
    tick();
    restart_n = 1'b1;
  endtask

  // Run with row_ready high until dut_b offers row idx; bounded.
  task automatic wait_b_row(input int idx, input int budget);
    int n;
    n = 0;
    while (!(row_valid_w[1] && (int'(row_idx_w[1]) == idx)) && (n < budget)) begin
      tick();
      n++;
    end
    if (n >= budget) chk("wait_row_timeout", 32'(n), 32'(budget - 1));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_w != 2'b00) && (n < budget)) begin
      tick();
      n++;
    end
    if (n >= budget) chk("wait_idle_timeout", 32'(n), 32'(budget - 1));
  endtask

  initial begin
    logic [31:0] pool [4];
    int          low_left;
    pool[0] = 32'hA5A5_A5A5;
    pool[1] = 32'h0;
    pool[2] = 32'hF000_0001;
    pool[3] = 32'h1234_5678;

    restart_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    #1;
    restart_n = 1'b0;
    #1;
    tick();
    do_reset();

    // Basic frame, explicit values on the no-gap instance.
    drive(1'b1, 32'hF000_0001, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("basic_row0_valid", 32'(row_valid_w[0]), 32'd1);
    chk("basic_row0_data",  32'(row_data_w[0]),  32'h1);
    for (int i = 1; i < ROWS; i++) begin
      tick();
      chk($sformatf("basic_idx%0d", i),  32'(row_idx_w[0]),  32'(i));
      chk($sformatf("basic_data%0d", i), 32'(row_data_w[0]), (i == ROWS - 1) ? 32'hF : 32'h0);
    end
    tick();
    chk("basic_frame_done", 32'(frame_done_w[0]), 32'd1);
    wait_idle(100);

    // Gap + backpressure on row 3, with a new board offered mid-frame.
    tick();
    drive(1'b1, 32'h8765_4321, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    wait_b_row(3, 60);
    drive(1'b1, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_busy_not_ready", 32'(board_ready_w[1]), 32'd0);
      chk("bp_idx_held",       32'(row_idx_w[1]),     32'd3);
      chk("bp_data_held",      32'(row_data_w[1]),    32'h4);
      drive(1'b0, 32'h1234_5678, (i == 2));
    end
    wait_idle(100);

    // Back-to-back: new board held valid through the frame_done cycle.
    tick();
    drive(1'b1, 32'h0F0F_F0F0, 1'b1);
    tick();
    drive(1'b1, 32'h3C3C_C3C3, 1'b1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (frame_done_w[1]) begin
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk("b2b_row0_valid", 32'(row_valid_w[1]), 32'd1);
        chk("b2b_row0_idx",   32'(row_idx_w[1]),   32'd0);
        break;
      end
    end
    drive(1'b0, 32'h0, 1'b1);
    wait_idle(200);

    // Reset mid-frame after the row 4 handshake.
    tick();
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    wait_b_row(4, 60);
    tick();
    do_reset();
    drive(1'b1, 32'h5555_AAAA, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    chk("post_reset_idx", 32'(row_idx_w[1]), 32'd0);
    wait_idle(100);

    // Repeated board, then all-zero board.
    for (int j = 0; j < 3; j++) begin
      tick();
      drive(1'b1, (j == 2) ? 32'h0 : 32'hA5A5_A5A5, 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b1);
      chk($sformatf("chg_busy%0d", j), 32'(busy_w[1]), (CHG && (j == 1)) ? 32'd0 : 32'd1);
      wait_idle(100);
    end

    // Randomized traffic with occasional mid-frame resets.
    low_left = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      drive(($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : $urandom,
            ($urandom_range(0, 9) < 7));
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
